// File: rtl/ll_nxt_ptr_arb_if.sv
// Bundle of the read/write requester, nxt_ptr_logic and response signals around ll_nxt_ptr_arb.
// master: the arbiter's view. slave: the environment's view (requesters + nxt_ptr_logic).
interface ll_nxt_ptr_arb_if #(
  parameter int unsigned PTR_WD = 8
);
  logic              rd_req_vld;
  logic              rd_req_pop;
  logic [PTR_WD-1:0] rd_node_at_pos;
  logic              wr_req_vld;
  logic [PTR_WD-1:0] wr_node_at_pos;
  logic              req_vld_to_nxt_ptr;
  logic [1:0]        req_op_to_nxt_ptr;
  logic [PTR_WD-1:0] node_at_pos_to_nxt_ptr;
  logic              nxt_ptr_vld;
  logic [PTR_WD-1:0] nxt_ptr_data;
  logic              rd_gnt;
  logic              wr_gnt;
  logic              rd_rsp_vld;
  logic              wr_rsp_vld;
  logic [PTR_WD-1:0] rsp_ptr;
  logic              rsp_err;
  logic              arb_timeout_err;
  logic              arb_busy;

  modport master (
    input  rd_req_vld, rd_req_pop, rd_node_at_pos, wr_req_vld, wr_node_at_pos,
    input  nxt_ptr_vld, nxt_ptr_data,
    output req_vld_to_nxt_ptr, req_op_to_nxt_ptr, node_at_pos_to_nxt_ptr,
    output rd_gnt, wr_gnt, rd_rsp_vld, wr_rsp_vld, rsp_ptr, rsp_err,
    output arb_timeout_err, arb_busy
  );

  modport slave (
    output rd_req_vld, rd_req_pop, rd_node_at_pos, wr_req_vld, wr_node_at_pos,
    output nxt_ptr_vld, nxt_ptr_data,
    input  req_vld_to_nxt_ptr, req_op_to_nxt_ptr, node_at_pos_to_nxt_ptr,
    input  rd_gnt, wr_gnt, rd_rsp_vld, wr_rsp_vld, rsp_ptr, rsp_err,
    input  arb_timeout_err, arb_busy
  );
endinterface

// File: rtl/ll_nxt_ptr_arb.sv
// Arbiter in front of nxt_ptr_logic: grants one of the read/write linked-list controllers,
// issues a single operation, waits (with timeout) for the pointer and returns it to the owner.
// Optional macro LL_NXT_PTR_ARB_RR_EN: round-robin on ties instead of fixed read priority.
module ll_nxt_ptr_arb #(
  parameter int unsigned PTR_WD      = 8,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned TO_CNT_WD   = 7
) (
  input logic              clk,
  input logic              reset_n,
  ll_nxt_ptr_arb_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp, StResp} state_e;
  typedef enum logic {OwnRd = 1'b0, OwnWr = 1'b1} owner_e;

  localparam logic [TO_CNT_WD-1:0] ToLast = TO_CNT_WD'(TIMEOUT_CYC - 1);

  state_e             state_q;
  owner_e             owner_q;
  logic [TO_CNT_WD-1:0] to_cnt_q;
  logic               req_vld_q;
  logic [1:0]         op_q;
  logic [PTR_WD-1:0]  pos_q;
  logic               rd_gnt_q;
  logic               wr_gnt_q;
  logic               rd_rsp_vld_q;
  logic               wr_rsp_vld_q;
  logic [PTR_WD-1:0]  rsp_ptr_q;
  logic               rsp_err_q;
  logic               timeout_err_q;
  logic               busy_q;
  logic               pick_wr;

`ifdef LL_NXT_PTR_ARB_RR_EN
  // Set when the most recent grant went to the writer; reset to writer so read wins the first tie.
  logic last_wr_q;

  // Tie goes to whichever side was not granted last.
  always_comb begin
    pick_wr = bus.wr_req_vld & (~bus.rd_req_vld | ~last_wr_q);
  end

  // Remember the last granted side at each grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_wr_q <= 1'b1;
    end else if (state_q == StIdle && (bus.rd_req_vld || bus.wr_req_vld)) begin
      last_wr_q <= pick_wr;
    end
  end
`else
  // Fixed priority: the writer wins only when the reader is not requesting.
  always_comb begin
    pick_wr = bus.wr_req_vld & ~bus.rd_req_vld;
  end
`endif

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      owner_q       <= OwnRd;
      to_cnt_q      <= '0;
      req_vld_q     <= 1'b0;
      op_q          <= 2'b00;
      pos_q         <= '0;
      rd_gnt_q      <= 1'b0;
      wr_gnt_q      <= 1'b0;
      rd_rsp_vld_q  <= 1'b0;
      wr_rsp_vld_q  <= 1'b0;
      rsp_ptr_q     <= '0;
      rsp_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      req_vld_q    <= 1'b0;
      rd_gnt_q     <= 1'b0;
      wr_gnt_q     <= 1'b0;
      rd_rsp_vld_q <= 1'b0;
      wr_rsp_vld_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.rd_req_vld || bus.wr_req_vld) begin
            state_q   <= StIssue;
            busy_q    <= 1'b1;
            req_vld_q <= 1'b1;
            owner_q   <= pick_wr ? OwnWr : OwnRd;
            rd_gnt_q  <= ~pick_wr;
            wr_gnt_q  <= pick_wr;
            op_q      <= pick_wr ? 2'b10 : {1'b0, bus.rd_req_pop};
            pos_q     <= pick_wr ? bus.wr_node_at_pos : bus.rd_node_at_pos;
          end
        end
        StIssue: begin
          to_cnt_q <= '0;
          if (bus.nxt_ptr_vld) begin
            state_q      <= StResp;
            rsp_ptr_q    <= bus.nxt_ptr_data;
            rsp_err_q    <= 1'b0;
            rd_rsp_vld_q <= (owner_q == OwnRd);
            wr_rsp_vld_q <= (owner_q == OwnWr);
          end else begin
            state_q <= StWaitRsp;
          end
        end
        StWaitRsp: begin
          // A response arriving on the timeout cycle still counts as a good response.
          if (bus.nxt_ptr_vld) begin
            state_q      <= StResp;
            rsp_ptr_q    <= bus.nxt_ptr_data;
            rsp_err_q    <= 1'b0;
            rd_rsp_vld_q <= (owner_q == OwnRd);
            wr_rsp_vld_q <= (owner_q == OwnWr);
          end else if (to_cnt_q == ToLast) begin
            state_q       <= StResp;
            rsp_ptr_q     <= '0;
            rsp_err_q     <= 1'b1;
            timeout_err_q <= 1'b1;
            rd_rsp_vld_q  <= (owner_q == OwnRd);
            wr_rsp_vld_q  <= (owner_q == OwnWr);
          end else begin
            to_cnt_q <= to_cnt_q + TO_CNT_WD'(1);
          end
        end
        StResp: begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          to_cnt_q <= '0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_vld_to_nxt_ptr     = req_vld_q;
  assign bus.req_op_to_nxt_ptr      = op_q;
  assign bus.node_at_pos_to_nxt_ptr = pos_q;
  assign bus.rd_gnt                 = rd_gnt_q;
  assign bus.wr_gnt                 = wr_gnt_q;
  assign bus.rd_rsp_vld             = rd_rsp_vld_q;
  assign bus.wr_rsp_vld             = wr_rsp_vld_q;
  assign bus.rsp_ptr                = rsp_ptr_q;
  assign bus.rsp_err                = rsp_err_q;
  assign bus.arb_timeout_err        = timeout_err_q;
  assign bus.arb_busy               = busy_q;

endmodule
